jk_bank_driver: RTL and testbench
=================================

JK_BANK_DRIVER -- requirements
Module: jk_bank_driver

Interface
REQ-001 SHALL have parameter: WIDTH, 4, number of external negedge JK flip-flops driven.
REQ-002 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: preset_  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid  input  1  request present.
REQ-005 SHALL have port: req_ready  output  1  driver can accept a request.
REQ-006 SHALL have port: req_mode  input  2  operation: 00 load, 01 toggle, 10 clear, 11 set.
REQ-007 SHALL have port: req_data  input  WIDTH  load value (mode 00) or bit mask (modes 01/10/11).
REQ-008 SHALL have port: jk_j  output  WIDTH  J drive to the flip-flop bank.
REQ-009 SHALL have port: jk_k  output  WIDTH  K drive to the flip-flop bank.
REQ-010 SHALL have port: jk_clk  output  1  bank clock; the bank samples J/K on its falling edge.
REQ-011 SHALL have port: fb_q  input  WIDTH  readback of the bank Q outputs.
REQ-012 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port: err  output  1  readback mismatch flag, valid only while done=1.
REQ-014 SHALL have port: shadow  output  WIDTH  driver's model of the bank contents.
REQ-015 SHALL have port: err_count  output  8  saturating mismatch counter.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, PULSE_HI, PULSE_LO, SETTLE, CHECK.
REQ-017 SHALL assert req_ready only in IDLE; a handshake (req_valid & req_ready) SHALL capture req_mode/req_data and move the FSM to SETUP.
REQ-018 SHALL ignore req_valid outside IDLE; captured mode/data SHALL stay stable until CHECK.
REQ-019 SETUP SHALL drive J/K from the captured request, held through PULSE_HI, PULSE_LO and SETTLE:
  - load: J=data, K=~data
  - toggle: J=K=mask
  - clear: J=0, K=mask
  - set: J=mask, K=0
REQ-020 SHALL drive jk_clk=1 only in PULSE_HI, producing exactly one falling edge per request, at entry to PULSE_LO.
REQ-021 SHALL drive J=K=0 in IDLE and CHECK; J/K SHALL never change while jk_clk=1.
REQ-022 SHALL compute expected = JK next-state of shadow under the applied J/K, per bit: 00 hold, 01 clear, 10 set, 11 invert.
REQ-023 In CHECK SHALL compare fb_q to expected, pulse done=1 for one cycle, set err=(fb_q!=expected), and return to IDLE.
REQ-024 On match SHALL load shadow=expected; on mismatch SHALL load shadow=fb_q (resync) and increment err_count, saturating at 8'hFF.
REQ-025 Latency: handshake edge to done=1 SHALL be exactly 5 clk cycles; back-to-back throughput SHALL be one request per 6 cycles.
REQ-026 A mask of all zeros SHALL still run the full sequence, producing a hold with expected=shadow.

Reset
REQ-027 preset_=0 SHALL immediately, without waiting for clk:
  - force IDLE, jk_j=0, jk_k=0, jk_clk=0, done=0, err=0, err_count=0
  - set shadow to all ones, matching the bank, which shares preset_
REQ-028 preset_ asserted mid-operation SHALL abort the request without producing done.
REQ-029 After preset_ deasserts, req_ready SHALL be 1 at the first clk edge.

Verification
REQ-030 Reset, then load 4'hA with fb_q modelled by an ideal negedge JK bank -> done after 5 cycles, err=0, shadow=4'hA, one jk_clk pulse.
REQ-031 From shadow 4'hA, toggle mask 4'hF -> J=K=4'hF during pulse, shadow=4'h5, err=0.
REQ-032 From shadow 4'h5, clear mask 4'h4 then set mask 4'h8 back-to-back -> shadow 4'h1 then 4'h9, done 6 cycles apart.
REQ-033 Force fb_q stuck at 4'h0 on set mask 4'h3 -> err=1 with done, shadow=4'h0, err_count=1; 256 forced mismatches -> err_count=8'hFF.
REQ-034 Assert preset_ during PULSE_HI -> jk_clk=0, J=K=0, no done pulse, shadow=4'hF, req_ready=1 after release.
REQ-035 Hold req_valid high with changing req_data during an operation -> only the IDLE-sampled request executes.

Source files
------------

// File: rtl/jk_bank_driver.sv
// Sequencer for a bank of external negedge JK flip-flops: applies one J/K
// pattern per request, strobes the bank clock once, then checks the readback.
module jk_bank_driver #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             preset_,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_mode,
    input  logic [WIDTH-1:0] req_data,
    output logic [WIDTH-1:0] jk_j,
    output logic [WIDTH-1:0] jk_k,
    output logic             jk_clk,
    input  logic [WIDTH-1:0] fb_q,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] shadow,
    output logic [7:0]       err_count
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        PULSE_HI = 3'd2,
        PULSE_LO = 3'd3,
        SETTLE   = 3'd4,
        CHECK    = 3'd5
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [1:0]       cap_mode;
    logic [WIDTH-1:0] cap_data;
    logic [WIDTH-1:0] req_j;
    logic [WIDTH-1:0] req_k;
    logic [WIDTH-1:0] expected;
    logic             accept;

    assign accept = req_valid && (state == IDLE);

    always_ff @(posedge clk or negedge preset_) begin
        if (!preset_) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (req_valid) next_state = SETUP;
            SETUP:    next_state = PULSE_HI;
            PULSE_HI: next_state = PULSE_LO;
            PULSE_LO: next_state = SETTLE;
            SETTLE:   next_state = CHECK;
            CHECK:    next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // The request is frozen at the handshake so J/K cannot move mid-pulse.
    always_ff @(posedge clk or negedge preset_) begin
        if (!preset_) begin
            cap_mode <= 2'b00;
            cap_data <= '0;
        end else if (accept) begin
            cap_mode <= req_mode;
            cap_data <= req_data;
        end
    end

    always_comb begin
        req_j = '0;
        req_k = '0;
        case (cap_mode)
            2'b00: begin
                req_j = cap_data;
                req_k = ~cap_data;
            end
            2'b01: begin
                req_j = cap_data;
                req_k = cap_data;
            end
            2'b10: begin
                req_j = '0;
                req_k = cap_data;
            end
            default: begin
                req_j = cap_data;
                req_k = '0;
            end
        endcase
    end

    assign expected = (req_j & ~shadow) | (~req_k & shadow);

    always_comb begin
        req_ready = 1'b0;
        jk_clk    = 1'b0;
        jk_j      = '0;
        jk_k      = '0;
        case (state)
            IDLE: req_ready = 1'b1;
            SETUP, PULSE_LO, SETTLE: begin
                jk_j = req_j;
                jk_k = req_k;
            end
            PULSE_HI: begin
                jk_clk = 1'b1;
                jk_j   = req_j;
                jk_k   = req_k;
            end
            default: ;
        endcase
    end

    // On a mismatch the shadow resyncs to what the bank actually holds.
    always_ff @(posedge clk or negedge preset_) begin
        if (!preset_) begin
            done      <= 1'b0;
            err       <= 1'b0;
            shadow    <= '1;
            err_count <= 8'h00;
        end else begin
            done <= (state == CHECK);
            err  <= (state == CHECK) && (fb_q != expected);
            if (state == CHECK) begin
                if (fb_q == expected) begin
                    shadow <= expected;
                end else begin
                    shadow <= fb_q;
                    if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed bench for jk_bank_driver with an ideal negedge JK bank and a
// transaction-level model checked against the outputs every cycle.
module tb_jk_bank_driver;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             preset_ = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_mode = 2'b00;
    logic [WIDTH-1:0] req_data = '0;
    logic [WIDTH-1:0] jk_j;
    logic [WIDTH-1:0] jk_k;
    logic             jk_clk;
    logic [WIDTH-1:0] fb_q;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] shadow;
    logic [7:0]       err_count;

    logic             force_en = 1'b0;
    logic [WIDTH-1:0] force_val = '0;
    logic [WIDTH-1:0] bank_q = '1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int jk_falls = 0;
    int done_events = 0;

    // Transaction-level model: age counts clock edges since the handshake.
    int               m_age = 0;
    logic [WIDTH-1:0] m_j = '0;
    logic [WIDTH-1:0] m_k = '0;
    logic [WIDTH-1:0] m_shadow = '1;
    logic [WIDTH-1:0] m_bank = '1;
    logic [7:0]       m_cnt = 8'h00;
    logic             m_err = 1'b0;
    logic             p_err = 1'b0;
    logic [WIDTH-1:0] p_shadow = '0;

    jk_bank_driver #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .preset_   (preset_),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_mode  (req_mode),
        .req_data  (req_data),
        .jk_j      (jk_j),
        .jk_k      (jk_k),
        .jk_clk    (jk_clk),
        .fb_q      (fb_q),
        .done      (done),
        .err       (err),
        .shadow    (shadow),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    always @(negedge jk_clk or negedge preset_) begin
        if (!preset_) bank_q <= '1;
        else          bank_q <= jk_next(bank_q, jk_j, jk_k);
    end

    assign fb_q = force_en ? force_val : bank_q;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge jk_clk) if (preset_) jk_falls <= jk_falls + 1;

    always @(negedge clk) if (done) done_events <= done_events + 1;

    function automatic logic [WIDTH-1:0] j_of(input logic [1:0] mode, input logic [WIDTH-1:0] data);
        case (mode)
            2'b00:   return data;
            2'b01:   return data;
            2'b10:   return '0;
            default: return data;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] k_of(input logic [1:0] mode, input logic [WIDTH-1:0] data);
        case (mode)
            2'b00:   return ~data;
            2'b01:   return data;
            2'b10:   return data;
            default: return '0;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] jk_next(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] j,
                                                 input logic [WIDTH-1:0] k);
        logic [WIDTH-1:0] r;
        for (int b = 0; b < WIDTH; b++) begin
            case ({j[b], k[b]})
                2'b00:   r[b] = q[b];
                2'b01:   r[b] = 1'b0;
                2'b10:   r[b] = 1'b1;
                default: r[b] = ~q[b];
            endcase
        end
        return r;
    endfunction

    always @(posedge clk or negedge preset_) begin
        if (!preset_) begin
            m_age    <= 0;
            m_shadow <= '1;
            m_bank   <= '1;
            m_cnt    <= 8'h00;
        end else begin
            if ((m_age == 0 || m_age == 6) && req_valid) begin
                m_age  <= 1;
                m_j    <= j_of(req_mode, req_data);
                m_k    <= k_of(req_mode, req_data);
                m_bank <= jk_next(m_bank, j_of(req_mode, req_data), k_of(req_mode, req_data));
                p_err  <= (force_en ? force_val : jk_next(m_bank, j_of(req_mode, req_data), k_of(req_mode, req_data)))
                          != jk_next(m_shadow, j_of(req_mode, req_data), k_of(req_mode, req_data));
                p_shadow <= force_en ? force_val : jk_next(m_bank, j_of(req_mode, req_data), k_of(req_mode, req_data));
            end else if (m_age >= 1 && m_age <= 5) begin
                m_age <= m_age + 1;
            end else begin
                m_age <= 0;
            end
            if (m_age == 5) begin
                m_shadow <= p_shadow;
                m_err    <= p_err;
                if (p_err && m_cnt != 8'hFF) m_cnt <= m_cnt + 8'd1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("req_ready", req_ready, (m_age == 0 || m_age == 6));
        checkOutput("jk_clk", jk_clk, (m_age == 2));
        checkOutput("jk_j", jk_j, (m_age >= 1 && m_age <= 4) ? m_j : '0);
        checkOutput("jk_k", jk_k, (m_age >= 1 && m_age <= 4) ? m_k : '0);
        checkOutput("done", done, (m_age == 6));
        if (m_age == 6) checkOutput("err", err, m_err);
        checkOutput("shadow", shadow, m_shadow);
        checkOutput("err_count", err_count, m_cnt);
    end

    task automatic applyStimulus(input logic [1:0] mode, input logic [WIDTH-1:0] data);
        @(negedge clk);
        req_mode  = mode;
        req_data  = data;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        hs_cyc    = cyc;
    endtask

    task automatic waitDone(output int lat, output logic [WIDTH-1:0] pj, output logic [WIDTH-1:0] pk);
        logic found;
        found = 1'b0;
        lat   = -1;
        pj    = '0;
        pk    = '0;
        for (int i = 0; i < 20; i++) begin
            if (jk_clk) begin
                pj = jk_j;
                pk = jk_k;
            end
            if (done) begin
                found = 1'b1;
                lat   = cyc - hs_cyc;
                break;
            end
            @(negedge clk);
        end
        checkOutput("done_timeout", found, 1'b1);
    endtask

    initial begin
        int               lat;
        int               falls0;
        int               ndone;
        int               dcyc[2];
        logic [WIDTH-1:0] dsh[2];
        logic [WIDTH-1:0] pj;
        logic [WIDTH-1:0] pk;

        #1 preset_ = 1'b0;
        #1;
        checkOutput("reset_async_shadow", shadow, 4'hF);
        checkOutput("reset_async_jk_clk", jk_clk, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("reset_err_count", err_count, 8'h00);
        checkOutput("reset_done", done, 1'b0);
        #2 preset_ = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", req_ready, 1'b1);

        falls0 = jk_falls;
        applyStimulus(2'b00, 4'hA);
        waitDone(lat, pj, pk);
        checkOutput("load_latency", lat, 5);
        checkOutput("load_err", err, 1'b0);
        checkOutput("load_shadow", shadow, 4'hA);
        checkOutput("load_jk_pulses", jk_falls - falls0, 1);
        checkOutput("load_pulse_j", pj, 4'hA);
        checkOutput("load_pulse_k", pk, 4'h5);

        applyStimulus(2'b01, 4'hF);
        waitDone(lat, pj, pk);
        checkOutput("toggle_pulse_j", pj, 4'hF);
        checkOutput("toggle_pulse_k", pk, 4'hF);
        checkOutput("toggle_shadow", shadow, 4'h5);
        checkOutput("toggle_err", err, 1'b0);

        // Back-to-back clear then set, request held valid across the operation.
        ndone = 0;
        dcyc[0] = 0;
        dcyc[1] = 0;
        dsh[0] = '0;
        dsh[1] = '0;
        @(negedge clk);
        req_mode  = 2'b10;
        req_data  = 4'h4;
        req_valid = 1'b1;
        @(negedge clk);
        req_mode = 2'b11;
        req_data = 4'h8;
        for (int i = 0; i < 30 && ndone < 2; i++) begin
            @(negedge clk);
            if (ndone == 1 && cyc == dcyc[0] + 1) req_valid = 1'b0;
            if (done) begin
                dcyc[ndone] = cyc;
                dsh[ndone]  = shadow;
                ndone++;
            end
        end
        req_valid = 1'b0;
        checkOutput("b2b_done_count", ndone, 2);
        checkOutput("b2b_spacing", dcyc[1] - dcyc[0], 6);
        checkOutput("b2b_clear_shadow", dsh[0], 4'h1);
        checkOutput("b2b_set_shadow", dsh[1], 4'h9);

        // Inputs churn while busy; only the IDLE-sampled toggle of bit 0 runs.
        @(negedge clk);
        req_mode  = 2'b01;
        req_data  = 4'h1;
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                req_valid = 1'b0;
                break;
            end
            req_mode = 2'b00;
            req_data = cyc[3:0];
        end
        req_valid = 1'b0;
        checkOutput("hold_valid_done", done, 1'b1);
        checkOutput("hold_valid_shadow", shadow, 4'h8);

        force_en  = 1'b1;
        force_val = 4'h0;
        applyStimulus(2'b11, 4'h3);
        waitDone(lat, pj, pk);
        checkOutput("stuck_err", err, 1'b1);
        checkOutput("stuck_shadow", shadow, 4'h0);
        checkOutput("stuck_err_count", err_count, 8'h01);
        for (int i = 1; i < 256; i++) begin
            applyStimulus(2'b11, 4'h3);
            waitDone(lat, pj, pk);
        end
        checkOutput("saturated_err_count", err_count, 8'hFF);
        force_en = 1'b0;

        applyStimulus(2'b00, 4'h5);
        for (int i = 0; i < 5 && !jk_clk; i++) @(negedge clk);
        checkOutput("reached_pulse_hi", jk_clk, 1'b1);
        falls0 = done_events;
        #2 preset_ = 1'b0;
        #1;
        checkOutput("abort_jk_clk", jk_clk, 1'b0);
        checkOutput("abort_jk_j", jk_j, 4'h0);
        checkOutput("abort_jk_k", jk_k, 4'h0);
        checkOutput("abort_shadow", shadow, 4'hF);
        checkOutput("abort_err_count", err_count, 8'h00);
        repeat (2) @(negedge clk);
        #2 preset_ = 1'b1;
        @(negedge clk);
        checkOutput("abort_ready", req_ready, 1'b1);
        repeat (8) @(negedge clk);
        checkOutput("abort_no_done", done_events - falls0, 0);

        applyStimulus(2'b00, 4'h6);
        waitDone(lat, pj, pk);
        checkOutput("post_reset_shadow", shadow, 4'h6);
        checkOutput("post_reset_err", err, 1'b0);
        checkOutput("post_reset_latency", lat, 5);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
